// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, default limits and dimension legality check for the conv loop sequencer
package conv_pkg;

    localparam int CONV_MAXN = 16;
    localparam int CONV_MAXM = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } conv_loop_state_t;

    // A legal job needs non-empty image and kernel, kernel no larger than image, both within the hardware limits.
    function automatic logic dims_legal(input int unsigned n, input int unsigned m,
                                        input int unsigned maxn, input int unsigned maxm);
        return (n != 0) && (m != 0) && (m <= n) && (n <= maxn) && (m <= maxm);
    endfunction

endpackage

// File: rtl/conv_idx_counter.sv
// rtl/conv_idx_counter.sv - wrap counter 0..limit with clear, increment and carry-out for loop chaining
module conv_idx_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         incr_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_nxt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next value is exported so the owner can register outputs derived from the post-advance index.
    always_comb begin
        wrap_o = incr_i && (cnt_q == limit_i);
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (wrap_o) begin
            cnt_d = '0;
        end else if (incr_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Index register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/conv_loop_ctrl.sv
// rtl/conv_loop_ctrl.sv - 2D convolution loop sequencer (r,c,i,j) issuing one MAC beat per tap; optional CONV_LOOP_STALL_CNT_EN
module conv_loop_ctrl
    import conv_pkg::*;
#(
    parameter int MAXN = CONV_MAXN,
    parameter int MAXM = CONV_MAXM,
    parameter int DIMW = $clog2(MAXN + 1),
    parameter int XAW  = $clog2(MAXN * MAXN),
    parameter int WAW  = $clog2(MAXM * MAXM)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [DIMW-1:0] n_dim,
    input  logic [DIMW-1:0] m_dim,
    output logic            beat_valid,
    input  logic            beat_ready,
    output logic [XAW-1:0]  addr_x,
    output logic [WAW-1:0]  addr_w,
    output logic            acc_clr,
    output logic            acc_last,
    output logic            busy,
    output logic            done,
`ifdef CONV_LOOP_STALL_CNT_EN
    output logic [31:0]     stall_cnt,
`endif
    output logic            err
);

    conv_loop_state_t state_q, state_d;
    logic [DIMW-1:0]  n_q, m_q;
    logic [DIMW-1:0]  m_lim, p_lim, m_lim_use;
    logic             beat_valid_q, beat_valid_d;
    logic             done_q, err_q, err_d;
    logic [XAW-1:0]   addr_x_q, addr_x_d;
    logic [WAW-1:0]   addr_w_q, addr_w_d;
    logic             acc_clr_q, acc_clr_d, acc_last_q, acc_last_d;

    logic             start_acc, legal, hs, cnt_clr, load;
    logic [DIMW-1:0]  j_cnt, i_cnt, c_cnt, r_cnt;
    logic [DIMW-1:0]  j_nxt, i_nxt, c_nxt, r_nxt;
    logic             j_wrap, i_wrap, c_wrap, r_wrap;

    assign start_acc = start && (state_q == IDLE);
    assign legal     = dims_legal(32'(n_dim), 32'(m_dim), MAXN, MAXM);
    assign hs        = beat_valid_q && beat_ready;
    assign cnt_clr   = (state_q != RUN);
    assign m_lim     = m_q - DIMW'(1);
    assign p_lim     = n_q - m_q;
    // While idle the freshly sampled kernel size decides whether the very first beat also closes its window.
    assign m_lim_use = (state_q == IDLE) ? (m_dim - DIMW'(1)) : m_lim;

    // Loop nest, innermost first: j -> i -> c -> r; the r carry marks the final beat's handshake.
    conv_idx_counter #(.W(DIMW)) u_j (
        .clk(clk), .reset(reset), .clr_i(cnt_clr), .incr_i(hs),
        .limit_i(m_lim), .cnt_o(j_cnt), .cnt_nxt_o(j_nxt), .wrap_o(j_wrap)
    );
    conv_idx_counter #(.W(DIMW)) u_i (
        .clk(clk), .reset(reset), .clr_i(cnt_clr), .incr_i(j_wrap),
        .limit_i(m_lim), .cnt_o(i_cnt), .cnt_nxt_o(i_nxt), .wrap_o(i_wrap)
    );
    conv_idx_counter #(.W(DIMW)) u_c (
        .clk(clk), .reset(reset), .clr_i(cnt_clr), .incr_i(i_wrap),
        .limit_i(p_lim), .cnt_o(c_cnt), .cnt_nxt_o(c_nxt), .wrap_o(c_wrap)
    );
    conv_idx_counter #(.W(DIMW)) u_r (
        .clk(clk), .reset(reset), .clr_i(cnt_clr), .incr_i(c_wrap),
        .limit_i(p_lim), .cnt_o(r_cnt), .cnt_nxt_o(r_nxt), .wrap_o(r_wrap)
    );

    // Beat fields for the index that will be current after this edge; the true addresses are below
    // 2^XAW / 2^WAW, so evaluating modulo the output width gives exact results.
    always_comb begin
        addr_x_d   = (XAW'(r_nxt) + XAW'(i_nxt)) * XAW'(n_q) + XAW'(c_nxt) + XAW'(j_nxt);
        addr_w_d   = WAW'(i_nxt) * WAW'(m_q) + WAW'(j_nxt);
        acc_clr_d  = (i_nxt == '0) && (j_nxt == '0);
        acc_last_d = (i_nxt == m_lim_use) && (j_nxt == m_lim_use);
        load       = (start_acc && legal) || (hs && !r_wrap);
    end

    // Sequencer FSM: illegal jobs go straight to FIN to report err with done.
    always_comb begin
        state_d      = state_q;
        beat_valid_d = beat_valid_q;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (legal) begin
                        state_d      = RUN;
                        beat_valid_d = 1'b1;
                    end else begin
                        state_d = FIN;
                        err_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (r_wrap) begin
                    state_d      = FIN;
                    beat_valid_d = 1'b0;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, latched dimensions and registered beat outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            n_q          <= '0;
            m_q          <= '0;
            beat_valid_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            addr_x_q     <= '0;
            addr_w_q     <= '0;
            acc_clr_q    <= 1'b0;
            acc_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_valid_q <= beat_valid_d;
            done_q       <= (state_d == FIN);
            err_q        <= err_d;
            if (start_acc) begin
                n_q <= n_dim;
                m_q <= m_dim;
            end
            if (load) begin
                addr_x_q   <= addr_x_d;
                addr_w_q   <= addr_w_d;
                acc_clr_q  <= acc_clr_d;
                acc_last_q <= acc_last_d;
            end
        end
    end

`ifdef CONV_LOOP_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Cycles the datapath back-pressured an offered beat; saturating, kept after done for readout.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (start_acc) begin
            stall_cnt_q <= '0;
        end else if ((state_q == RUN) && beat_valid_q && !beat_ready && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign beat_valid = beat_valid_q;
    assign addr_x     = addr_x_q;
    assign addr_w     = addr_w_q;
    assign acc_clr    = acc_clr_q;
    assign acc_last   = acc_last_q;
    assign busy       = (state_q == RUN);
    assign done       = done_q;
    assign err        = err_q;

    // Indices are consumed only through their next-state values.
    logic unused_idx;
    assign unused_idx = ^{j_cnt, i_cnt, c_cnt, r_cnt};

endmodule

// File: tb/tb_conv_loop_ctrl.sv
// tb/tb_conv_loop_ctrl.sv - randomized self-checking bench for conv_loop_ctrl against a loop-nest reference model
module tb_conv_loop_ctrl;

    localparam int DIMW = 5;
    localparam int XAW  = 8;
    localparam int WAW  = 5;

    logic            clk = 1'b0;
    logic            reset, start, beat_ready;
    logic [DIMW-1:0] n_dim, m_dim;
    logic            beat_valid, acc_clr, acc_last, busy, done, err;
    logic [XAW-1:0]  addr_x;
    logic [WAW-1:0]  addr_w;
`ifdef CONV_LOOP_STALL_CNT_EN
    logic [31:0]     stall_cnt;
`endif

    conv_loop_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .n_dim(n_dim), .m_dim(m_dim),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .addr_x(addr_x), .addr_w(addr_w),
        .acc_clr(acc_clr), .acc_last(acc_last), .busy(busy), .done(done),
`ifdef CONV_LOOP_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int x;
        int w;
        bit clr;
        bit last;
    } beat_t;

    beat_t exp_q[$];

    // Reference: every output pixel, every tap, in r/c/i/j nesting order.
    function automatic void build(input int n, input int m);
        int p;
        beat_t b;
        p = n - m + 1;
        exp_q.delete();
        for (int r = 0; r < p; r++)
            for (int c = 0; c < p; c++)
                for (int i = 0; i < m; i++)
                    for (int j = 0; j < m; j++) begin
                        b.x    = (r + i) * n + (c + j);
                        b.w    = i * m + j;
                        b.clr  = (i == 0) && (j == 0);
                        b.last = (i == m - 1) && (j == m - 1);
                        exp_q.push_back(b);
                    end
    endfunction

    // mode 0: ready always high, 1: ready toggling 1/0, 2: random ready
    task automatic run_seq(input int n, input int m, input int mode, input bit inject);
        int  idx, cyc, last_hs, stalls;
        bit  held, got_done, rdy;
        logic [XAW-1:0] px;
        logic [WAW-1:0] pw;
        logic pc, pl;
        idx = 0; cyc = 0; last_hs = -10; stalls = 0; held = 0; got_done = 0;
        px = '0; pw = '0; pc = 0; pl = 0;
        build(n, m);
        @(negedge clk);
        start = 1'b1; n_dim = DIMW'(n); m_dim = DIMW'(m); beat_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!got_done && cyc < 20000) begin
            if (done) begin
                got_done = 1;
                check_eq("done_timing", cyc, last_hs + 1);
                check_eq("beats_total", idx, exp_q.size());
                check_eq("err_on_done", err, 0);
                check_eq("valid_after_done", beat_valid, 0);
                check_eq("busy_in_fin", busy, 0);
`ifdef CONV_LOOP_STALL_CNT_EN
                check_eq("stall_cnt", stall_cnt, stalls);
`endif
            end else begin
                if (cyc == 0) check_eq("busy_run", busy, 1);
                start = inject && (cyc == 3);
                if (start) begin
                    n_dim = DIMW'(6);
                    m_dim = DIMW'(2);
                end
                if (!beat_valid) begin
                    check_eq("valid_in_run", beat_valid, 1);
                    beat_ready = 1'($urandom_range(0, 1));
                end else if (idx >= exp_q.size()) begin
                    check_eq("extra_beat", idx, exp_q.size() - 1);
                    beat_ready = 1'b1;
                end else begin
                    if (held) begin
                        check_eq("hold_addr_x", addr_x, px);
                        check_eq("hold_addr_w", addr_w, pw);
                        check_eq("hold_clr", acc_clr, pc);
                        check_eq("hold_last", acc_last, pl);
                    end
                    if (mode == 0) rdy = 1;
                    else if (mode == 1) rdy = (cyc % 2 == 0);
                    else rdy = 1'($urandom_range(0, 1));
                    beat_ready = rdy;
                    if (rdy) begin
                        check_eq("addr_x", addr_x, exp_q[idx].x);
                        check_eq("addr_w", addr_w, exp_q[idx].w);
                        check_eq("acc_clr", acc_clr, exp_q[idx].clr);
                        check_eq("acc_last", acc_last, exp_q[idx].last);
                        idx++;
                        last_hs = cyc;
                        held = 0;
                    end else begin
                        held = 1;
                        stalls++;
                        px = addr_x; pw = addr_w; pc = acc_clr; pl = acc_last;
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        beat_ready = 1'b0;
        if (!got_done) check_eq("done_timeout", 0, 1);
        check_eq("done_one_cycle", done, 0);
        check_eq("idle_busy", busy, 0);
    endtask

    task automatic run_illegal(input int n, input int m);
        bit seen;
        seen = 0;
        @(negedge clk);
        start = 1'b1; n_dim = DIMW'(n); m_dim = DIMW'(m); beat_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            check_eq("illegal_no_beat", beat_valid, 0);
            check_eq("illegal_no_busy", busy, 0);
            if (done) begin
                seen = 1;
                check_eq("illegal_err", err, 1);
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) check_eq("illegal_done_timeout", 0, 1);
        @(negedge clk);
        check_eq("illegal_done_clear", done, 0);
        check_eq("illegal_err_clear", err, 0);
        beat_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; beat_ready = 1'b0; n_dim = '0; m_dim = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", beat_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_addr_x", addr_x, 0);
        check_eq("rst_addr_w", addr_w, 0);
        check_eq("rst_acc", {acc_clr, acc_last}, 0);
`ifdef CONV_LOOP_STALL_CNT_EN
        check_eq("rst_stall_cnt", stall_cnt, 0);
`endif
        reset = 1'b0;

        run_seq(4, 3, 0, 0);
        run_seq(4, 3, 1, 0);
        run_seq(3, 1, 2, 0);
        run_seq(4, 4, 2, 0);
        run_seq(1, 1, 0, 0);
        run_seq(16, 5, 2, 0);

        run_illegal(2, 3);
        run_illegal(0, 1);
        run_illegal(3, 0);
        run_illegal(17, 1);
        run_illegal(8, 6);

        // Reset while beat 10 of N=4,M=3 is on the bus.
        build(4, 3);
        @(negedge clk);
        start = 1'b1; n_dim = DIMW'(4); m_dim = DIMW'(3); beat_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("pre_reset_addr_x", addr_x, exp_q[9].x);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_reset_busy", busy, 0);
        check_eq("mid_reset_valid", beat_valid, 0);
        check_eq("mid_reset_done", done, 0);
        check_eq("mid_reset_addr_x", addr_x, 0);
        reset = 1'b0;
        beat_ready = 1'b0;
        @(negedge clk);
        check_eq("post_reset_done", done, 0);
        run_seq(4, 3, 0, 0);

        run_seq(4, 3, 2, 1);

        for (int t = 0; t < 6; t++) begin
            int n, m;
            n = $urandom_range(1, 12);
            m = $urandom_range(1, (n < 5) ? n : 5);
            run_seq(n, m, 2, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
